div_i8: RTL

Sequential signed integer divider. It is the inverse companion to the team's combinational signed multiplier and uses the same sign-magnitude scheme: operand magnitudes are divided unsigned, then signs are reapplied. It uses restoring division, one quotient bit per cycle, behind a valid/ready handshake on both sides. It is used in MX scale and normalisation paths where one divide is needed every few cycles and a combinational divider is too costly.

---
 rtl/div_i8_if.sv | 23 ++
 rtl/div_i8.sv | 123 ++++++++++++
 2 files changed

// File: rtl/div_i8_if.sv
// Operand/result handshake bundle for the sequential signed divider.
interface div_i8_if #(parameter int bit_width = 8);
  logic                 i_valid;
  logic                 o_ready;
  logic [bit_width-1:0] i_dividend;
  logic [bit_width-1:0] i_divisor;
  logic                 o_valid;
  logic                 i_ready;
  logic [bit_width-1:0] o_quot;
  logic [bit_width-1:0] o_rem;
  logic                 o_dz;
  logic                 o_ovf;

  modport master (
    output i_valid, i_dividend, i_divisor, i_ready,
    input  o_ready, o_valid, o_quot, o_rem, o_dz, o_ovf
  );

  modport slave (
    input  i_valid, i_dividend, i_divisor, i_ready,
    output o_ready, o_valid, o_quot, o_rem, o_dz, o_ovf
  );
endinterface

// File: rtl/div_i8.sv
// Sequential signed restoring divider: magnitudes divided unsigned one bit per
// cycle, signs reapplied at the end; fixed latency regardless of operand values.
module div_i8 #(
  parameter int bit_width = 8
) (
  input logic     i_clk,
  input logic     i_rst,
  div_i8_if.slave bus
);
  localparam int CW = $clog2(bit_width + 1);
  localparam logic [bit_width-1:0] MAX_POS = {1'b0, {(bit_width-1){1'b1}}};
  localparam logic [bit_width-1:0] MIN_NEG = {1'b1, {(bit_width-1){1'b0}}};
  localparam logic [bit_width-1:0] NEG_ONE = {bit_width{1'b1}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [bit_width-1:0] dvd_sh, dvs_mag, quo, dvd_orig;
  logic [bit_width:0]   prem;
  logic [CW-1:0]        cnt;
  logic                 q_sign, r_sign, dz, ovf;
  logic [bit_width-1:0] quot_r, rem_r;
  logic                 dz_r, ovf_r;

  logic [bit_width+1:0] shifted, diff;
  logic                 q_bit;
  logic [bit_width:0]   prem_nxt;
  logic [bit_width-1:0] res_q, res_r;

  function automatic logic [bit_width-1:0] mag(input logic [bit_width-1:0] x);
    return x[bit_width-1] ? -x : x;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.i_valid)  state_nxt = CALC;
      CALC:    if (cnt == '0)    state_nxt = DONE;
      DONE:    if (bus.i_ready)  state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // One restoring step: bring in the next dividend bit, keep the trial
  // difference only when it did not go negative.
  always_comb begin
    shifted  = {prem, dvd_sh[bit_width-1]};
    diff     = shifted - {2'b00, dvs_mag};
    q_bit    = ~diff[bit_width+1];
    prem_nxt = q_bit ? diff[bit_width:0] : shifted[bit_width:0];
  end

  always_comb begin
    res_q = q_sign ? -quo : quo;
    res_r = r_sign ? -prem[bit_width-1:0] : prem[bit_width-1:0];
    if (ovf) begin
      res_q = MAX_POS;
      res_r = '0;
    end else if (dz) begin
      res_q = r_sign ? MIN_NEG : MAX_POS;
      res_r = dvd_orig;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dvd_sh   <= '0;
      dvs_mag  <= '0;
      dvd_orig <= '0;
      quo      <= '0;
      prem     <= '0;
      cnt      <= '0;
      q_sign   <= 1'b0;
      r_sign   <= 1'b0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
      quot_r   <= '0;
      rem_r    <= '0;
      dz_r     <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.i_valid) begin
          dvd_sh   <= mag(bus.i_dividend);
          dvs_mag  <= mag(bus.i_divisor);
          dvd_orig <= bus.i_dividend;
          q_sign   <= bus.i_dividend[bit_width-1] ^ bus.i_divisor[bit_width-1];
          r_sign   <= bus.i_dividend[bit_width-1];
          dz       <= (bus.i_divisor == '0);
          ovf      <= (bus.i_dividend == MIN_NEG) && (bus.i_divisor == NEG_ONE);
          prem     <= '0;
          quo      <= '0;
          cnt      <= CW'(bit_width);
        end
        CALC: if (cnt != '0) begin
          prem   <= prem_nxt;
          quo    <= {quo[bit_width-2:0], q_bit};
          dvd_sh <= {dvd_sh[bit_width-2:0], 1'b0};
          cnt    <= cnt - CW'(1);
        end else begin
          // Last CALC cycle: results latched once, held through DONE.
          quot_r <= res_q;
          rem_r  <= res_r;
          dz_r   <= dz;
          ovf_r  <= ovf;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready = (state == IDLE);
  assign bus.o_valid = (state == DONE);
  assign bus.o_quot  = quot_r;
  assign bus.o_rem   = rem_r;
  assign bus.o_dz    = dz_r;
  assign bus.o_ovf   = ovf_r;
endmodule
